io_bus_arbiter: RTL and testbench



---
 rtl/io_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_io_bus_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin CPU/DMA arbiter and transaction sequencer for the shared I/O bus.
// Every granted transaction completes exactly once: on device ack, unmapped decode or timeout.
module io_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] cpu_m_addr,
    input  logic [15:0] cpu_m_data_out,
    input  logic        cpu_m_wr_en,
    input  logic [1:0]  cpu_m_bytesel,
    input  logic        cpu_m_access,
    output logic        cpu_m_ack,
    output logic [15:0] cpu_m_data_in,
    input  logic [18:0] dma_m_addr,
    input  logic [15:0] dma_m_data_out,
    input  logic        dma_m_wr_en,
    input  logic [1:0]  dma_m_bytesel,
    input  logic        dma_m_access,
    output logic        dma_m_ack,
    output logic [15:0] dma_m_data_in,
    output logic [18:0] io_m_addr,
    output logic [15:0] io_m_data_out,
    output logic        io_m_wr_en,
    output logic [1:0]  io_m_bytesel,
    output logic        io_m_access,
    input  logic        io_m_ack,
    input  logic [15:0] io_m_data_in,
    input  logic        default_io_access,
    output logic        io_grant_dma,
    output logic        io_timeout
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     data_q, data_d;
    logic            tmo_q, tmo_d;
    logic            busy, acking;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (cpu_m_access || dma_m_access) begin
                    // owner 1 = DMA; on contention the requester not served last wins
                    owner_d = (cpu_m_access && dma_m_access) ? ~last_q : dma_m_access;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (io_m_ack) begin
                    data_d  = io_m_data_in;
                    tmo_d   = 1'b0;
                    state_d = ACK;
                end else if (default_io_access) begin
                    data_d  = 16'hFFFF;
                    tmo_d   = 1'b0;
                    state_d = ACK;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = 16'hFFFF;
                    tmo_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q == BUSY);
    assign acking = (state_q == ACK);

    // bus controls follow the owner combinationally so the decoder sees them stable all of BUSY
    assign io_m_access   = busy;
    assign io_m_addr     = busy ? (owner_q ? dma_m_addr : cpu_m_addr) : '0;
    assign io_m_data_out = busy ? (owner_q ? dma_m_data_out : cpu_m_data_out) : '0;
    assign io_m_wr_en    = busy & (owner_q ? dma_m_wr_en : cpu_m_wr_en);
    assign io_m_bytesel  = busy ? (owner_q ? dma_m_bytesel : cpu_m_bytesel) : '0;

    assign cpu_m_ack     = acking & ~owner_q;
    assign dma_m_ack     = acking & owner_q;
    assign cpu_m_data_in = cpu_m_ack ? data_q : '0;
    assign dma_m_data_in = dma_m_ack ? data_q : '0;
    assign io_grant_dma  = (busy | acking) & owner_q;
    assign io_timeout    = acking & tmo_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: randomized transaction-level checks of io_bus_arbiter against a behavioural model.
module tb_io_bus_arbiter;
    localparam int T = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] cpu_m_addr = '0, dma_m_addr = '0, io_m_addr;
    logic [15:0] cpu_m_data_out = '0, dma_m_data_out = '0, io_m_data_out;
    logic        cpu_m_wr_en = 1'b0, dma_m_wr_en = 1'b0, io_m_wr_en;
    logic [1:0]  cpu_m_bytesel = '0, dma_m_bytesel = '0, io_m_bytesel;
    logic        cpu_m_access = 1'b0, dma_m_access = 1'b0, io_m_access;
    logic        cpu_m_ack, dma_m_ack, io_grant_dma, io_timeout;
    logic [15:0] cpu_m_data_in, dma_m_data_in;
    logic        io_m_ack = 1'b0, default_io_access = 1'b0;
    logic [15:0] io_m_data_in = '0;

    int errors = 0;
    int checks = 0;
    bit last_dma = 1'b0;

    always #5 clk = ~clk;

    io_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .cpu_m_addr(cpu_m_addr), .cpu_m_data_out(cpu_m_data_out), .cpu_m_wr_en(cpu_m_wr_en),
        .cpu_m_bytesel(cpu_m_bytesel), .cpu_m_access(cpu_m_access), .cpu_m_ack(cpu_m_ack),
        .cpu_m_data_in(cpu_m_data_in),
        .dma_m_addr(dma_m_addr), .dma_m_data_out(dma_m_data_out), .dma_m_wr_en(dma_m_wr_en),
        .dma_m_bytesel(dma_m_bytesel), .dma_m_access(dma_m_access), .dma_m_ack(dma_m_ack),
        .dma_m_data_in(dma_m_data_in),
        .io_m_addr(io_m_addr), .io_m_data_out(io_m_data_out), .io_m_wr_en(io_m_wr_en),
        .io_m_bytesel(io_m_bytesel), .io_m_access(io_m_access), .io_m_ack(io_m_ack),
        .io_m_data_in(io_m_data_in), .default_io_access(default_io_access),
        .io_grant_dma(io_grant_dma), .io_timeout(io_timeout)
    );

    // mode 0: device acks after w wait states (none if w >= T); 1: unmapped; 2: ack and unmapped together
    task automatic run_txn(input bit c, input bit d, input int mode, input int w, input string nm);
        bit own, exp_to;
        int n;
        logic [15:0] dev, exp_data;
        logic [18:0] exp_addr;
        logic [15:0] exp_wdata;
        logic exp_wr;
        logic [1:0] exp_bs;
        @(negedge clk);
        checks++;
        if (io_m_access !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_gap: io_m_access=%0b want 0", nm, io_m_access);
        end
        if (c) begin
            cpu_m_addr = 19'($urandom); cpu_m_data_out = 16'($urandom);
            cpu_m_wr_en = 1'($urandom); cpu_m_bytesel = 2'($urandom);
        end
        if (d) begin
            dma_m_addr = 19'($urandom); dma_m_data_out = 16'($urandom);
            dma_m_wr_en = 1'($urandom); dma_m_bytesel = 2'($urandom);
        end
        cpu_m_access = c;
        dma_m_access = d;
        own = (c && d) ? !last_dma : d;
        dev = 16'($urandom);
        io_m_data_in = dev;
        exp_to = (mode == 0) && (w > T - 1);
        n = (mode != 0) ? 2 : (exp_to ? T + 1 : 2 + w);
        exp_data = (mode == 1 || exp_to) ? 16'hFFFF : dev;
        exp_addr = own ? dma_m_addr : cpu_m_addr;
        exp_wdata = own ? dma_m_data_out : cpu_m_data_out;
        exp_wr = own ? dma_m_wr_en : cpu_m_wr_en;
        exp_bs = own ? dma_m_bytesel : cpu_m_bytesel;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k < n) begin
                checks++;
                if (io_m_access !== 1'b1 || io_m_addr !== exp_addr || io_grant_dma !== own
                    || cpu_m_ack !== 1'b0 || dma_m_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy[%0d]: access=%0b addr=%h grant=%0b acks=%0b%0b want 1 %h %0b 00",
                             nm, k, io_m_access, io_m_addr, io_grant_dma, cpu_m_ack, dma_m_ack, exp_addr, own);
                end
                if (k == 1) begin
                    checks++;
                    if (io_m_data_out !== exp_wdata || io_m_wr_en !== exp_wr || io_m_bytesel !== exp_bs) begin
                        errors++;
                        $display("FAIL %s ctrl: data=%h wr=%0b bs=%0b want %h %0b %0b",
                                 nm, io_m_data_out, io_m_wr_en, io_m_bytesel, exp_wdata, exp_wr, exp_bs);
                    end
                end
                io_m_ack = (mode == 0 && k == 1 + w) || (mode == 2 && k == 1);
                default_io_access = (mode != 0 && k == 1);
            end else begin
                checks++;
                if (cpu_m_ack !== !own || dma_m_ack !== own || io_timeout !== exp_to
                    || io_m_access !== 1'b0 || io_grant_dma !== own) begin
                    errors++;
                    $display("FAIL %s ack_cycle %0d: cpu_ack=%0b dma_ack=%0b tmo=%0b access=%0b grant=%0b want %0b %0b %0b 0 %0b",
                             nm, k, cpu_m_ack, dma_m_ack, io_timeout, io_m_access, io_grant_dma, !own, own, exp_to, own);
                end
                checks++;
                if ((own ? dma_m_data_in : cpu_m_data_in) !== exp_data
                    || (own ? cpu_m_data_in : dma_m_data_in) !== 16'h0) begin
                    errors++;
                    $display("FAIL %s ack_data: cpu=%h dma=%h want owner %h other 0",
                             nm, cpu_m_data_in, dma_m_data_in, exp_data);
                end
                io_m_ack = 1'b0;
                default_io_access = 1'b0;
            end
        end
        last_dma = own;
        if (own) dma_m_access = 1'b0;
        else cpu_m_access = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({io_m_access, cpu_m_ack, dma_m_ack, io_grant_dma, io_timeout} !== 5'b0
            || io_m_addr !== '0 || cpu_m_data_in !== '0 || dma_m_data_in !== '0) begin
            errors++;
            $display("FAIL reset_state: access=%0b acks=%0b%0b grant=%0b tmo=%0b addr=%h want all 0",
                     io_m_access, cpu_m_ack, dma_m_ack, io_grant_dma, io_timeout, io_m_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        last_dma = 1'b0;
    endtask

    task automatic test_cpu_read();
        run_txn(1, 0, 0, 0, "cpu_read");
        run_txn(1, 0, 0, 3, "cpu_wait3");
    endtask

    task automatic test_contention();
        run_txn(1, 1, 0, 0, "contend1");
        run_txn(1, 1, 0, 1, "contend2");
        run_txn(1, 1, 0, 0, "contend3");
        cpu_m_access = 1'b0;
        dma_m_access = 1'b0;
    endtask

    task automatic test_unmapped();
        run_txn(1, 0, 1, 0, "unmapped");
        run_txn(0, 1, 1, 0, "unmapped_dma");
    endtask

    task automatic test_timeout();
        run_txn(1, 0, 0, 100, "timeout");
        run_txn(1, 0, 0, T - 1, "ack_at_limit");
        run_txn(0, 1, 0, T - 2, "ack_before_limit");
        run_txn(1, 0, 2, 0, "ack_and_unmapped");
    endtask

    task automatic test_ignored();
        @(negedge clk);
        io_m_ack = 1'b1;
        default_io_access = 1'b1;
        @(negedge clk);
        io_m_ack = 1'b0;
        default_io_access = 1'b0;
        checks++;
        if (io_m_access !== 1'b0 || cpu_m_ack !== 1'b0 || dma_m_ack !== 1'b0 || io_timeout !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored: access=%0b acks=%0b%0b tmo=%0b want 0",
                     io_m_access, cpu_m_ack, dma_m_ack, io_timeout);
        end
    endtask

    task automatic test_reset_mid_busy();
        bit seen = 1'b0;
        @(negedge clk);
        dma_m_addr = 19'h1234;
        dma_m_wr_en = 1'b1;
        dma_m_access = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (io_m_access !== 1'b0 || io_grant_dma !== 1'b0 || dma_m_ack !== 1'b0 || io_m_addr !== '0) begin
            errors++;
            $display("FAIL reset_mid_busy: access=%0b grant=%0b dma_ack=%0b addr=%h want 0",
                     io_m_access, io_grant_dma, dma_m_ack, io_m_addr);
        end
        dma_m_access = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        last_dma = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (dma_m_ack) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL lost_txn: dma_m_ack=1 want 0 after reset");
        end
        run_txn(1, 0, 0, 2, "after_reset_cpu");
        run_txn(1, 1, 0, 0, "after_reset_contend");
        cpu_m_access = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int r;
            bit c, d;
            r = int'($urandom_range(1, 3));
            c = r[0];
            d = r[1];
            run_txn(c, d, int'($urandom_range(0, 2)), int'($urandom_range(0, 20)), "random");
        end
        cpu_m_access = 1'b0;
        dma_m_access = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_contention();
        test_unmapped();
        test_timeout();
        test_ignored();
        test_reset_mid_busy();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
